// File: rtl/flash_read_arbiter.sv
// flash_read_arbiter: shares one spi_master flash-read engine between two
// requesters. Round-robin arbitration, one outstanding read at a time, and a
// watchdog that resets the spi_master and reports an error if a read stalls.
module flash_read_arbiter #(
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int RESET_CYCLES   = 16
) (
  input  logic        clk,
  input  logic        reset,
  // port 0
  input  logic        req0_valid,
  input  logic [23:0] req0_addr,
  output logic        req0_ready,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_data,
  output logic        rsp0_err,
  // port 1
  input  logic        req1_valid,
  input  logic [23:0] req1_addr,
  output logic        req1_ready,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_data,
  output logic        rsp1_err,
  // spi_master side
  output logic        spi_reset,
  input  logic        spi_addr_buffer_free,
  output logic        spi_addr_en,
  output logic [23:0] spi_addr_data,
  input  logic        spi_rd_data_available,
  output logic        spi_rd_ack,
  input  logic [31:0] spi_rd_data
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] REC_LAST   = RW'(RESET_CYCLES - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_DATA = 3'd2;
  localparam logic [2:0] S_RESPOND   = 3'd3;
  localparam logic [2:0] S_RECOVER   = 3'd4;
  localparam logic [2:0] S_ERR_RSP   = 3'd5;

  logic [2:0]    state;
  logic [2:0]    state_next;
  logic [TW-1:0] timer;
  logic [RW-1:0] rec_cnt;
  logic          owner;        // 0: port 0 owns the transaction, 1: port 1
  logic          last_served;  // port that completed most recently
  logic [23:0]   addr_q;
  logic [31:0]   data_q;

  logic          grant0;
  logic          grant1;
  logic          accept;
  logic          rsp_ok;
  logic          rsp_fail;

  // Arbitration: a lone valid port wins; on a tie the port not served last wins.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    grant1 = 1'b0;
    grant0 = 1'b0;
    if (req1_valid && (!req0_valid || !last_served)) begin
      grant1 = 1'b1;
    end else if (req0_valid) begin
      grant0 = 1'b1;
    end
  end

  assign accept     = !reset && (state == S_IDLE) && spi_addr_buffer_free;
  assign req0_ready = accept && grant0;
  assign req1_ready = accept && grant1;

  // Next-state logic for the transaction sequencer.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept && (grant0 || grant1)) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        state_next = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        // Data arriving in the same cycle as the timeout still wins.
        if (spi_rd_data_available)    state_next = S_RESPOND;
        else if (timer == TIMER_LAST) state_next = S_RECOVER;
      end
      S_RESPOND: begin
        state_next = S_IDLE;
      end
      S_RECOVER: begin
        if (rec_cnt == REC_LAST) state_next = S_ERR_RSP;
      end
      S_ERR_RSP: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State, watchdog, recovery counter, round-robin pointer and latched transaction data.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state       <= S_IDLE;
      timer       <= '0;
      rec_cnt     <= '0;
      owner       <= 1'b0;
      last_served <= 1'b1;   // makes port 0 the tie winner after reset
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (accept && (grant0 || grant1)) begin
            owner  <= grant1;
            addr_q <= grant1 ? req1_addr : req0_addr;
          end
        end
        S_ISSUE: begin
          timer <= '0;
        end
        S_WAIT_DATA: begin
          if (spi_rd_data_available) begin
            data_q <= spi_rd_data;
          end else if (timer == TIMER_LAST) begin
            rec_cnt <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_RESPOND: begin
          last_served <= owner;
        end
        S_RECOVER: begin
          if (rec_cnt != REC_LAST) rec_cnt <= rec_cnt + 1'b1;
        end
        S_ERR_RSP: begin
          last_served <= owner;
        end
        default: begin
          timer <= '0;
        end
      endcase
    end
  end

  // spi_master drive; everything except spi_reset is forced low while reset is high.
  assign spi_reset     = reset || (state == S_RECOVER);
  assign spi_addr_en   = !reset && (state == S_ISSUE);
  assign spi_addr_data = reset ? 24'd0 : addr_q;
  assign spi_rd_ack    = !reset && (state == S_WAIT_DATA) && spi_rd_data_available;

  // Response steering: one-cycle pulse to the owner, data and err zero otherwise.
  assign rsp_ok   = !reset && (state == S_RESPOND);
  assign rsp_fail = !reset && (state == S_ERR_RSP);

  assign rsp0_valid = (rsp_ok || rsp_fail) && !owner;
  assign rsp0_data  = (rsp_ok && !owner) ? data_q : 32'd0;
  assign rsp0_err   = rsp_fail && !owner;

  assign rsp1_valid = (rsp_ok || rsp_fail) && owner;
  assign rsp1_data  = (rsp_ok && owner) ? data_q : 32'd0;
  assign rsp1_err   = rsp_fail && owner;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Directed bench for flash_read_arbiter with a small behavioural spi_master.
// Flash content model: the byte at address a is a[7:0].
module tb_flash_read_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [23:0] req0_addr, req1_addr;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_data, rsp1_data;
  logic        rsp0_err, rsp1_err;
  logic        spi_reset;
  logic        spi_addr_buffer_free;
  logic        spi_addr_en;
  logic [23:0] spi_addr_data;
  logic        spi_rd_data_available;
  logic        spi_rd_ack;
  logic [31:0] spi_rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  // spi model controls
  int spi_delay = 3;
  bit spi_hang  = 1'b0;

  // monitor counters
  int rsp0_cnt = 0, rsp1_cnt = 0, spi_rst_cnt = 0, ack_cnt = 0;
  int both_ready_cnt = 0, idle_nonzero_cnt = 0;

  flash_read_arbiter #(.TIMEOUT_CYCLES(8), .RESET_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .spi_reset(spi_reset), .spi_addr_buffer_free(spi_addr_buffer_free),
    .spi_addr_en(spi_addr_en), .spi_addr_data(spi_addr_data),
    .spi_rd_data_available(spi_rd_data_available), .spi_rd_ack(spi_rd_ack),
    .spi_rd_data(spi_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] flash_word(input logic [23:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {b, b + 8'd1, b + 8'd2, b + 8'd3};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  // Runs cycles until a response appears (bounded), dropping valid on handshake.
  // cyc counts sampled cycles, starting with the current one as 1.
  task automatic wait_rsp(output int port, output logic [31:0] data,
                          output logic err, output int cyc);
    bit drop0, drop1;
    port = -1; data = '0; err = 1'b0; cyc = 0;
    for (int i = 1; i <= 200 && port < 0; i++) begin
      drop0 = 1'b0;
      drop1 = 1'b0;
      sample;
      if (req0_valid && req0_ready) drop0 = 1'b1;
      if (req1_valid && req1_ready) drop1 = 1'b1;
      if (rsp0_valid) begin
        port = 0; data = rsp0_data; err = rsp0_err; cyc = i;
      end else if (rsp1_valid) begin
        port = 1; data = rsp1_data; err = rsp1_err; cyc = i;
      end
      step;
      if (drop0) req0_valid = 1'b0;
      if (drop1) req1_valid = 1'b0;
    end
    if (port < 0) $display("FAIL wait_rsp: no response within 200 cycles");
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    spi_rd_data_available = 1'b0;
    step;
    step;
    reset = 1'b0;
  endtask

  // Behavioural spi_master: answers an address strobe after spi_delay cycles.
  initial begin
    logic [23:0] a;
    spi_rd_data_available = 1'b0;
    spi_rd_data = '0;
    forever begin
      @(negedge clk);
      if (spi_addr_en === 1'b1 && !spi_hang) begin
        a = spi_addr_data;
        repeat (spi_delay) @(posedge clk);
        #1;
        spi_rd_data_available = 1'b1;
        spi_rd_data = flash_word(a);
        @(posedge clk);
        #1;
        spi_rd_data_available = 1'b0;
        spi_rd_data = '0;
      end
    end
  end

  // Cycle monitor: pulse counts and invariants sampled away from the clock edge.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (rsp0_valid) rsp0_cnt <= rsp0_cnt + 1;
      if (rsp1_valid) rsp1_cnt <= rsp1_cnt + 1;
      if (spi_reset)  spi_rst_cnt <= spi_rst_cnt + 1;
      if (spi_rd_ack) ack_cnt <= ack_cnt + 1;
      if (req0_ready && req1_ready) both_ready_cnt <= both_ready_cnt + 1;
      if ((!rsp0_valid && (rsp0_data != 0 || rsp0_err)) ||
          (!rsp1_valid && (rsp1_data != 0 || rsp1_err)))
        idle_nonzero_cnt <= idle_nonzero_cnt + 1;
    end
  end

  initial begin
    int          port, cyc, snap_a, snap_b, bp_ready;
    logic [31:0] data;
    logic        err;

    reset = 1'b1;
    req0_valid = 1'b1; req0_addr = 24'h100000;
    req1_valid = 1'b0; req1_addr = 24'h0;
    spi_addr_buffer_free = 1'b1;

    // ---- reset state (port 0 valid to show ready is held low) ----
    step; step;
    sample;
    check("rst_spi_reset", 32'(spi_reset), 32'd1);
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    check("rst_addr_en", 32'(spi_addr_en), 32'd0);
    check("rst_addr_data", 32'(spi_addr_data), 32'd0);
    check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    step;
    reset = 1'b0;

    // ---- single read on port 0, cycle-exact latency ----
    sample;                                   // T
    check("t1_ready0", 32'(req0_ready), 32'd1);
    check("t1_ready1", 32'(req1_ready), 32'd0);
    check("t1_spi_reset_low", 32'(spi_reset), 32'd0);
    step; req0_valid = 1'b0;
    sample;                                   // T+1
    check("t1_addr_en", 32'(spi_addr_en), 32'd1);
    check("t1_addr_data", 32'(spi_addr_data), 32'h100000);
    step; sample;                             // T+2
    check("t1_no_ack_t2", 32'(spi_rd_ack), 32'd0);
    step; sample; step; sample;               // T+4
    check("t1_ack", 32'(spi_rd_ack), 32'd1);
    check("t1_no_rsp_yet", 32'(rsp0_valid), 32'd0);
    step; sample;                             // T+5
    check("t1_rsp0_valid", 32'(rsp0_valid), 32'd1);
    check("t1_rsp0_data", rsp0_data, 32'h00010203);
    check("t1_rsp0_err", 32'(rsp0_err), 32'd0);
    check("t1_rsp1_quiet", 32'(rsp1_valid), 32'd0);
    step; sample;                             // T+6
    check("t1_rsp0_pulse", 32'(rsp0_valid), 32'd0);
    step;
    check("t1_ack_count", 32'(ack_cnt), 32'd1);
    check("t1_rsp1_count", 32'(rsp1_cnt), 32'd0);

    // ---- simultaneous requests after reset ----
    req0_valid = 1'b1; req0_addr = 24'h100000;
    req1_valid = 1'b1; req1_addr = 24'h100004;
    apply_reset;
    wait_rsp(port, data, err, cyc);
    check("t2_first_port", 32'(port), 32'd0);
    check("t2_first_data", data, 32'h00010203);
    wait_rsp(port, data, err, cyc);
    check("t2_second_port", 32'(port), 32'd1);
    check("t2_second_data", data, 32'h04050607);
    req0_valid = 1'b1; req0_addr = 24'h000020;
    req1_valid = 1'b1; req1_addr = 24'h000044;
    wait_rsp(port, data, err, cyc);
    check("t2_third_port", 32'(port), 32'd0);
    check("t2_third_data", data, flash_word(24'h000020));
    wait_rsp(port, data, err, cyc);
    check("t2_fourth_port", 32'(port), 32'd1);
    check("t2_fourth_data", data, flash_word(24'h000044));

    // ---- back-pressure from spi_addr_buffer_free ----
    spi_addr_buffer_free = 1'b0;
    req1_valid = 1'b1; req1_addr = 24'h200008;
    bp_ready = 0;
    snap_a = 0;
    repeat (10) begin
      sample;
      if (req1_ready) bp_ready++;
      if (spi_addr_en) snap_a++;
      step;
    end
    check("t3_ready_held_low", 32'(bp_ready), 32'd0);
    check("t3_no_addr_en", 32'(snap_a), 32'd0);
    spi_addr_buffer_free = 1'b1;
    sample;
    check("t3_ready_on_free", 32'(req1_ready), 32'd1);
    step; req1_valid = 1'b0;
    sample;
    check("t3_addr_en_next", 32'(spi_addr_en), 32'd1);
    check("t3_addr_data", 32'(spi_addr_data), 32'h200008);
    step;
    wait_rsp(port, data, err, cyc);
    check("t3_port", 32'(port), 32'd1);
    check("t3_data", data, 32'h08090a0b);

    // ---- watchdog timeout and recovery ----
    spi_hang = 1'b1;
    snap_a = spi_rst_cnt;
    req0_valid = 1'b1; req0_addr = 24'h300000;
    wait_rsp(port, data, err, cyc);
    check("t4_port", 32'(port), 32'd0);
    check("t4_err", 32'(err), 32'd1);
    check("t4_data_zero", data, 32'd0);
    check("t4_latency", 32'(cyc), 32'd15);
    check("t4_spi_reset_cycles", 32'(spi_rst_cnt - snap_a), 32'd4);
    spi_hang = 1'b0;
    req1_valid = 1'b1; req1_addr = 24'h300004;
    wait_rsp(port, data, err, cyc);
    check("t4_after_port", 32'(port), 32'd1);
    check("t4_after_err", 32'(err), 32'd0);
    check("t4_after_data", data, 32'h04050607);
    check("t4_after_latency", 32'(cyc), 32'd6);

    // ---- data on the timeout boundary ----
    spi_delay = 8;
    snap_a = spi_rst_cnt;
    req0_valid = 1'b1; req0_addr = 24'h000010;
    wait_rsp(port, data, err, cyc);
    check("t5_port", 32'(port), 32'd0);
    check("t5_err", 32'(err), 32'd0);
    check("t5_data", data, 32'h10111213);
    check("t5_latency", 32'(cyc), 32'd11);
    check("t5_no_spi_reset", 32'(spi_rst_cnt - snap_a), 32'd0);
    spi_delay = 3;

    // ---- reset during WAIT_DATA ----
    spi_hang = 1'b1;
    snap_a = rsp0_cnt;
    snap_b = rsp1_cnt;
    req0_valid = 1'b1; req0_addr = 24'h400000;
    sample;
    check("t6_ready0", 32'(req0_ready), 32'd1);
    step; req0_valid = 1'b0;
    sample;
    check("t6_addr_en", 32'(spi_addr_en), 32'd1);
    step; step;                               // now in WAIT_DATA
    reset = 1'b1;
    sample;
    check("t6_spi_reset", 32'(spi_reset), 32'd1);
    check("t6_addr_en_low", 32'(spi_addr_en), 32'd0);
    check("t6_addr_data_low", 32'(spi_addr_data), 32'd0);
    check("t6_rsp0_low", 32'(rsp0_valid), 32'd0);
    step; sample;
    check("t6_spi_reset_held", 32'(spi_reset), 32'd1);
    step;
    reset = 1'b0;
    spi_hang = 1'b0;
    req1_valid = 1'b1; req1_addr = 24'h500000;
    sample;
    check("t6_post_spi_reset", 32'(spi_reset), 32'd0);
    check("t6_post_addr_data", 32'(spi_addr_data), 32'd0);
    check("t6_post_ready1", 32'(req1_ready), 32'd1);
    step; req1_valid = 1'b0;
    wait_rsp(port, data, err, cyc);
    check("t6_post_port", 32'(port), 32'd1);
    check("t6_post_data", data, 32'h00010203);
    check("t6_no_rsp0", 32'(rsp0_cnt - snap_a), 32'd0);
    check("t6_rsp1_once", 32'(rsp1_cnt - snap_b), 32'd1);

    // ---- global invariants ----
    step;
    check("never_both_ready", 32'(both_ready_cnt), 32'd0);
    check("idle_rsp_zero", 32'(idle_nonzero_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
